// File: rtl/tf_inv_arb.sv
// tf_inv_arb: round-robin front end that shares one fixed-latency
// transfer-function unit among NUM_REQ requesters. Each issue is tagged with
// its requester index, the tag travels alongside the unit pipeline, and the
// result lands in that requester's response register (valid/ready hold).
// Optional build macro TF_INV_ARB_STATS_EN adds issue/stall counters.
module tf_inv_arb #(
  parameter int NUM_REQ  = 4,
  parameter int BITS_IN  = 95,
  parameter int BITS_OUT = 64,
  parameter int TF_LAT   = 2,
  parameter int IDX_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BITS_IN-1:0]   req_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*BITS_OUT-1:0]  rsp_data,
  output logic [BITS_IN-1:0]           tf_ibus,
  input  logic [BITS_OUT-1:0]          tf_obus
`ifdef TF_INV_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_issue,
  output logic [31:0]                  stat_stall
`endif
);

  // Requester bookkeeping
  logic [NUM_REQ-1:0]          busy_q, busy_d;
  logic [NUM_REQ-1:0]          eligible_s;
  logic [NUM_REQ-1:0]          accept_s;
  logic [NUM_REQ-1:0]          grant_s;
  logic                        gnt_vld_s;
  logic [IDX_W-1:0]            gnt_idx_s;
  logic [IDX_W-1:0]            ptr_q, ptr_d;

  // Issue stage and tag pipeline (index 0 is aligned with tf_ibus,
  // index TF_LAT is aligned with tf_obus)
  logic [BITS_IN-1:0]          ibus_q, ibus_d;
  logic [TF_LAT:0]             tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]            tag_idx_q [TF_LAT+1];
  logic [IDX_W-1:0]            tag_idx_d [TF_LAT+1];

  // Response registers
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*BITS_OUT-1:0] rsp_data_q, rsp_data_d;

  // Eligibility: idle, or freeing its slot by accepting a response this cycle; nothing is granted in reset
  always_comb begin
    accept_s = rsp_valid_q & rsp_ready;
    if (rst) begin
      eligible_s = '0;
    end else begin
      eligible_s = req_valid & (~busy_q | accept_s);
    end
  end

  // Round-robin scan from the pointer; first eligible requester wins, pointer moves past it
  always_comb begin
    int cand;
    grant_s   = '0;
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    ptr_d     = ptr_q;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!gnt_vld_s && eligible_s[IDX_W'(cand)]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = IDX_W'(cand);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s) begin
      grant_s[gnt_idx_s] = 1'b1;
      if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Issue word (bubble of zeros when idle) and shift the {valid, idx} tag along the unit latency
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d[0] = gnt_idx_s;
    tag_vld_d[0] = gnt_vld_s;
    if (gnt_vld_s) begin
      ibus_d = req_data[int'(gnt_idx_s)*BITS_IN +: BITS_IN];
    end else begin
      ibus_d = '0;
    end
    for (int k = 1; k <= TF_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  // Busy flags and response capture/hold per requester
  always_comb begin
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        busy_d[i] = 1'b1;
      end else if (accept_s[i]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
      if (tag_vld_q[TF_LAT] && (tag_idx_q[TF_LAT] == IDX_W'(i))) begin
        rsp_valid_d[i]                        = 1'b1;
        rsp_data_d[i*BITS_OUT +: BITS_OUT]    = tf_obus;
      end else if (accept_s[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
  end

  // State registers; reset drops all in-flight tags so late unit results are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      ptr_q       <= '0;
      ibus_q      <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= TF_LAT; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      ibus_q      <= ibus_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int k = 0; k <= TF_LAT; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tf_ibus   = ibus_q;

`ifdef TF_INV_ARB_STATS_EN
  logic [31:0] stat_issue_q, stat_stall_q;

  // Issue counter per grant; stall counter when someone is waiting but every valid requester is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_q <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (gnt_vld_s) begin
        stat_issue_q <= stat_issue_q + 32'd1;
      end else begin
        stat_issue_q <= stat_issue_q;
      end
      if ((|req_valid) && !gnt_vld_s) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end else begin
        stat_stall_q <= stat_stall_q;
      end
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
